// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver.
//
// Recovers frames of the form: start bit (0), 8 data bits LSB first, an
// optional parity bit, and a stop bit (1). Each bit lasts PRESCALE clock
// cycles. Bits are resolved by a 2-of-3 majority vote taken around the middle
// of the bit period. A good frame is delivered on P_DATA with a one-cycle
// Data_Valid strobe. Parity and stop-bit failures give one-cycle error
// strobes instead.
//
// Ports
//   CLK          in   rising-edge clock; all logic runs in this domain
//   RST          in   synchronous reset, active low
//   RX_IN        in   serial line, idles high, asynchronous to CLK
//   PRESCALE     in   [5:0] clock cycles per bit (even, 8..32)
//   PAR_EN       in   1 = a parity bit follows the data bits
//   PAR_TYP      in   0 = even parity, 1 = odd parity
//   P_DATA       out  [7:0] last good byte; updates only with Data_Valid
//   Data_Valid   out  one-cycle strobe: good frame received
//   Parity_Error out  one-cycle strobe: parity bit mismatched
//   Stop_Error   out  one-cycle strobe: stop bit sampled as 0
// -----------------------------------------------------------------------------
module uart_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] PRESCALE,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       Data_Valid,
  output logic       Parity_Error,
  output logic       Stop_Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Two-flop synchronizer for the asynchronous serial line.
  logic       sync1_q;
  logic       rx_s_q;

  state_e     state_q,        state_d;
  logic [5:0] edge_cnt_q,     edge_cnt_d;
  logic [2:0] bit_cnt_q,      bit_cnt_d;

  // Frame settings, frozen for the duration of a frame.
  logic [5:0] prescale_q,     prescale_d;
  logic       par_en_q,       par_en_d;
  logic       par_typ_q,      par_typ_d;

  // Majority sampler: first two samples, then the voted bit.
  logic [1:0] samp_q,         samp_d;
  logic       samp_bit_q,     samp_bit_d;

  logic [7:0] shift_q,        shift_d;
  logic       par_err_q,      par_err_d;

  logic [7:0] p_data_q,       p_data_d;
  logic       data_valid_q,   data_valid_d;
  logic       parity_error_q, parity_error_d;
  logic       stop_error_q,   stop_error_d;

  // Positions within a bit period, derived from the latched prescale.
  logic [5:0] half;
  logic [5:0] pt_early;
  logic [5:0] pt_mid;
  logic [5:0] pt_late;
  logic [5:0] pt_eval;
  logic [5:0] pt_last;
  logic       at_eval;
  logic       at_last;

  assign half     = {1'b0, prescale_q[5:1]};
  assign pt_early = half - 6'd2;
  assign pt_mid   = half - 6'd1;
  assign pt_late  = half;
  assign pt_eval  = half + 6'd1;
  assign pt_last  = prescale_q - 6'd1;
  assign at_eval  = (edge_cnt_q == pt_eval);
  assign at_last  = (edge_cnt_q == pt_last);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    prescale_d     = prescale_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    samp_d         = samp_q;
    samp_bit_d     = samp_bit_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    p_data_d       = p_data_q;
    // Strobes are low unless the frame evaluation raises them this cycle.
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    // Bit-period counter and sampler run in every state except IDLE.
    if (state_q != S_IDLE) begin
      edge_cnt_d = at_last ? 6'd0 : edge_cnt_q + 6'd1;
      if (edge_cnt_q == pt_early) samp_d[0] = rx_s_q;
      if (edge_cnt_q == pt_mid)   samp_d[1] = rx_s_q;
      if (edge_cnt_q == pt_late) begin
        samp_bit_d = (samp_q[0] & samp_q[1]) |
                     (samp_q[0] & rx_s_q)    |
                     (samp_q[1] & rx_s_q);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        edge_cnt_d = 6'd0;
        if (!rx_s_q) begin
          state_d    = S_START;
          bit_cnt_d  = 3'd0;
          par_err_d  = 1'b0;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end

      S_START: begin
        // A high majority in the middle of the start bit is a glitch.
        if (at_eval && samp_bit_q) begin
          state_d    = S_IDLE;
          edge_cnt_d = 6'd0;
        end else if (at_last) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (at_eval) shift_d[bit_cnt_q] = samp_bit_q;
        if (at_last) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        // Expected bit is the data XOR, inverted for odd parity.
        if (at_eval) par_err_d = samp_bit_q ^ (^shift_q) ^ par_typ_q;
        if (at_last) state_d = S_STOP;
      end

      S_STOP: begin
        // Leave at the stop sample so the rest of the stop bit is spent in
        // IDLE, where a back-to-back start edge can be caught.
        if (at_eval) begin
          state_d        = S_IDLE;
          edge_cnt_d     = 6'd0;
          stop_error_d   = ~samp_bit_q;
          parity_error_d = par_err_q;
          if (samp_bit_q && !par_err_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        edge_cnt_d = 6'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: the synchronizer resets to the idle level (1) so that a line
      // held low through reset still shows up as a falling edge afterwards.
      sync1_q        <= 1'b1;
      rx_s_q         <= 1'b1;
      state_q        <= S_IDLE;
      edge_cnt_q     <= 6'd0;
      bit_cnt_q      <= 3'd0;
      prescale_q     <= 6'd8;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      samp_q         <= 2'b11;
      samp_bit_q     <= 1'b1;
      shift_q        <= 8'h00;
      par_err_q      <= 1'b0;
      p_data_q       <= 8'h00;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      sync1_q        <= RX_IN;
      rx_s_q         <= sync1_q;
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      prescale_q     <= prescale_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      samp_q         <= samp_d;
      samp_bit_q     <= samp_bit_d;
      shift_q        <= shift_d;
      par_err_q      <= par_err_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = data_valid_q;
  assign Parity_Error = parity_error_q;
  assign Stop_Error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// A serializer task drives directed frames onto RX_IN. Each frame pushes the
// expected strobe set, byte and strobe cycle into a scoreboard queue; a
// monitor pops and compares whenever the receiver raises any strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx dut (
    .CLK          (clk),
    .RST          (rst_n),
    .RX_IN        (rx_in),
    .PRESCALE     (prescale),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .P_DATA       (p_data),
    .Data_Valid   (data_valid),
    .Parity_Error (parity_error),
    .Stop_Error   (stop_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Monitor: any strobe must match the oldest expected frame.
  always @(negedge clk) begin
    if (data_valid || parity_error || stop_error) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, data_valid, parity_error, stop_error}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobes", {29'd0, data_valid, parity_error, stop_error},
              {29'd0, e.dv, e.pe, e.se});
        check("p_data", {24'd0, p_data}, {24'd0, e.data});
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Hold RX_IN at one bit level for p cycles; ends at posedge + 1.
  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) @(posedge clk);
    #1;
  endtask

  // Drive one frame and queue its expected outcome. Expected flags are
  // supplied by the caller from hand-computed parity/stop values.
  task automatic send_frame(input logic [7:0] data, input bit with_par,
                            input bit par_bit, input bit stop_bit, input int p,
                            input bit exp_pe, input bit exp_se);
    exp_t e;
    int   n;
    n    = with_par ? 10 : 9;
    e.pe = exp_pe;
    e.se = exp_se;
    e.dv = !exp_pe && !exp_se;
    if (e.dv) last_good = data;
    e.data = last_good;
    e.cyc  = cyc + 5 + n * p + p / 2;
    sb_q.push_back(e);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (with_par) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    rx_in = 1'b1;
  endtask

  // Bounded wait for every queued frame to be observed.
  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_in    = 1'b1;
    rst_n    = 1'b0;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // Reset state
    check("rst_p_data", {24'd0, p_data}, 32'h00);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_parity_error", {31'd0, parity_error}, 32'd0);
    check("rst_stop_error", {31'd0, stop_error}, 32'd0);

    // Good frame, P=8, no parity: strobe 81 cycles after start edge
    send_frame(8'hA5, 0, 0, 1, 8, 0, 0);
    wait_drain(200);
    idle(10);

    // Parity even, 0x3C has four ones -> parity bit 0
    par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h3C, 1, 0, 1, 8, 0, 0);
    wait_drain(200);
    idle(10);
    // Odd parity, correct bit 1
    par_typ = 1'b1;
    send_frame(8'h3C, 1, 1, 1, 8, 0, 0);
    wait_drain(200);
    idle(10);
    // Odd parity, wrong bit 0 -> parity error, P_DATA keeps 0x3C
    send_frame(8'h3C, 1, 0, 1, 8, 1, 0);
    wait_drain(200);
    idle(10);

    // Stop error, P=16: 0xFF with stop 0
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    send_frame(8'hFF, 0, 0, 0, 16, 0, 1);
    wait_drain(300);
    idle(40);
    // Good 0x12; settings changed mid-frame must be ignored
    fork
      send_frame(8'h12, 0, 0, 1, 16, 0, 0);
      begin
        repeat (40) @(posedge clk);
        #1;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
      end
    join
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    wait_drain(300);
    idle(20);

    // Both errors together: even parity, 0x01 needs parity 1, send 0; stop 0
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h01, 1, 0, 0, 8, 1, 1);
    wait_drain(200);
    idle(30);

    // False start: line low 3 cycles, then a good 0x5A
    prescale = 6'd16; par_en = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(60);
    send_frame(8'h5A, 0, 0, 1, 16, 0, 0);
    wait_drain(300);
    idle(10);

    // Back-to-back loopback, P=8, even parity (all three bytes have parity 0)
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h00, 1, 0, 1, 8, 0, 0);
    send_frame(8'hFF, 1, 0, 1, 8, 0, 0);
    send_frame(8'h81, 1, 0, 1, 8, 0, 0);
    wait_drain(200);
    idle(10);

    // Reset mid-frame during data bit 4 of 0xF0 (bits 4..7 and stop are 1,
    // so the line stays high after reset and no new frame starts)
    prescale = 6'd16; par_en = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 16);
    rx_in = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 8'h00;
    check("midrst_p_data", {24'd0, p_data}, 32'h00);
    check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_parity_error", {31'd0, parity_error}, 32'd0);
    check("midrst_stop_error", {31'd0, stop_error}, 32'd0);
    idle(7 + 3 * 16 + 16 + 32);
    send_frame(8'hC3, 0, 0, 1, 16, 0, 0);
    wait_drain(300);
    idle(20);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the downstream counterpart of the team's UART transmitter. It recovers frames from the serial line (`RX_IN`): start bit 0, 8 data bits LSB first, optional parity bit, and stop bit 1. It delivers each good byte on `P_DATA` with a one-cycle `Data_Valid` strobe, and flags parity and stop-bit failures with one-cycle error strobes. It is used on the receive side of the UART link and in loopback benches against the transmitter.

## Interface
- No parameters. The frame width of 8 data bits is fixed.
- `CLK` input 1: single clock, rising edge. All logic runs in this domain.
- `RST` input 1: reset, synchronous and active-low (0 = reset, sampled on `CLK` rising edge).
- `RX_IN` input 1: serial line, idles at 1. It is asynchronous to `CLK`.
- `PRESCALE` input 6: `CLK` cycles per bit. Legal values are even numbers from 8 to 32. Other values give undefined behaviour.
- `PAR_EN` input 1: 1 means a parity bit follows the data bits.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `P_DATA` output 8: last good received byte. Changes only on the `Data_Valid` cycle.
- `Data_Valid` output 1: one-cycle strobe, a good frame was received.
- `Parity_Error` output 1: one-cycle strobe, the received parity bit mismatched.
- `Stop_Error` output 1: one-cycle strobe, the stop bit sampled as 0.

## Operation
**Input synchronizer**
- `RX_IN` passes through a 2-flop synchronizer. The result is `rx_s`.
- All internal timing is relative to `rx_s`, which lags `RX_IN` by 2 cycles.

**Frame settings**
- `PRESCALE`, `PAR_EN` and `PAR_TYP` are latched on the IDLE→START transition.
- The latched values hold for the whole frame, so changes mid-frame have no effect.

**Counters**
- `edge_cnt` counts 0..`PRESCALE`-1 within each bit period.
- `bit_cnt` counts 0..7 during the data bits.

**Sampler**
- `rx_s` is sampled at `edge_cnt` = P/2-2, P/2-1 and P/2, where P is the latched `PRESCALE`.
- The 2-of-3 majority is registered as `samp_bit`, valid at `edge_cnt` = P/2+1.

**FSM states**
- IDLE: `edge_cnt` = 0. Go to START when `rx_s` == 0.
- START: at `edge_cnt` = P/2+1, if `samp_bit` == 1 it is a false start and the FSM returns to IDLE with no strobe. At `edge_cnt` = P-1, go to DATA.
- DATA: at P/2+1, shift `samp_bit` into bit position `bit_cnt` of the shift register, LSB first. At P-1, increment `bit_cnt`. After bit 7 at P-1, go to PARITY if `PAR_EN` is set, otherwise go to STOP.
- PARITY: at P/2+1, compare `samp_bit` with the expected bit. Expected = XOR of the 8 data bits when `PAR_TYP` = 0, and its inverse when `PAR_TYP` = 1. Record any mismatch. At P-1, go to STOP.
- STOP: at P/2+1, evaluate the frame and go to IDLE immediately. The second half of the stop bit is spent in IDLE, so a back-to-back start edge is caught.

**Frame evaluation**, registered and visible in the cycle after the STOP P/2+1 cycle:
- Stop bit 0 → `Stop_Error` = 1.
- Parity mismatch → `Parity_Error` = 1. Both error strobes can assert together.
- No error → `Data_Valid` = 1 and `P_DATA` = shift register.
- On any error, `Data_Valid` stays 0 and `P_DATA` holds its previous value.

**Reset** (`RST` = 0 on any cycle, including mid-frame):
- FSM goes to IDLE and counters clear.
- Synchronizer flops are set to 1.
- `P_DATA` = 0x00; `Data_Valid`, `Parity_Error` and `Stop_Error` = 0.
- The next frame is accepted only after a falling edge seen in IDLE.

**Line held low in IDLE:** START is re-entered each time and is aborted only by a 1 majority. A continuous 0 produces frames with `Stop_Error` = 1.

## Timing
- Start detect: IDLE sees `rx_s` = 0 at cycle t, and START begins with `edge_cnt` = 0 at t+1.
- Nominal bit k (k = 0 for start) occupies `edge_cnt` 0..P-1 of period k. Its sample point is P/2.
- Strobe latency:
  - From the first low `RX_IN` cycle: 2 (synchronizer) + 1 + N·P + P/2 + 2 cycles.
  - N = 9 without parity, 10 with parity.
  - Example: P = 8, no parity → 2+1+72+4+2 = 81 cycles.
- Every strobe is exactly 1 cycle wide.
- Minimum frame-to-frame spacing is one full stop bit. A start edge arriving anywhere after the stop-bit sample is accepted.
- Tolerates ±3% bit-rate mismatch at P = 16.

## Test plan
- **Good frame, no parity:** P = 8, `PAR_EN` = 0, send 0xA5 → exactly one `Data_Valid` pulse 81 cycles after the start edge, `P_DATA` = 0xA5, no error strobes.
- **Parity types:**
  - `PAR_EN` = 1, `PAR_TYP` = 0, send 0x3C with parity bit 0 → `Data_Valid`, `P_DATA` = 0x3C.
  - Repeat with `PAR_TYP` = 1 and parity bit 1 → `Data_Valid`.
  - Repeat with `PAR_TYP` = 1 and the wrong parity bit 0 → `Parity_Error` pulse only, `P_DATA` still 0x3C from the previous frame.
- **Stop error:** P = 16, send 0xFF with stop bit 0 → `Stop_Error` pulse, no `Data_Valid`. Then a good frame 0x12 → `Data_Valid`, `P_DATA` = 0x12.
- **False start:** P = 16, `RX_IN` low for 3 cycles, then high → no strobes, FSM back in IDLE. A following frame 0x5A is received correctly.
- **Back-to-back and loopback:** connect the transmitter's serial output (with bits stretched to P = 8 per bit) to `RX_IN`, and send 0x00, 0xFF, 0x81 with no idle gap, parity even → three `Data_Valid` pulses with matching bytes.
- **Reset mid-frame:** assert `RST` = 0 for 1 cycle during data bit 4 → all outputs 0, `P_DATA` = 0x00, no strobe for the aborted frame. A subsequent 0xC3 frame is received correctly.
